// File: rtl/axi_sram_slave_if.sv
// AXI3-subset bus bundle between a master and axi_sram_slave.
// The slave modport is seen from the RAM side; the master modport is the mirror image.
`timescale 1ns/1ps
interface axi_sram_slave_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awid, awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3-subset INCR-only slave RAM: independent read and write FSMs sharing one
// 32-bit word array, one beat per cycle on each channel.
`timescale 1ns/1ps
module axi_sram_slave #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    axi_sram_slave_if.slave  s_axi
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    wstate_t               r_wstate, w_wstate_nxt;
    rstate_t               r_rstate, w_rstate_nxt;
    logic [31:0]           r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_widx, r_ridx, w_raddr;
    logic [3:0]            r_wcnt, r_rcnt, r_bid, r_rid;
    logic [1:0]            r_bresp;
    logic [31:0]           r_rdata;
    logic                  w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic                  w_aw_hs, w_w_hs, w_w_end, w_ar_hs, w_r_hs, w_ren;
    logic                  w_unused;

    // Only the word-index bits of the byte addresses matter; the rest alias.
    assign w_unused = ^{s_axi.awaddr[31:ADDR_WIDTH+2], s_axi.awaddr[1:0],
                        s_axi.araddr[31:ADDR_WIDTH+2], s_axi.araddr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                if (s_axi.awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (s_axi.wvalid && (r_wcnt == 4'd0 || s_axi.wlast)) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (s_axi.bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (s_axi.arvalid) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (s_axi.rready && r_rcnt == 4'd0) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign w_aw_hs = s_axi.awvalid & w_awready;
    assign w_w_hs  = s_axi.wvalid & w_wready;
    assign w_w_end = w_w_hs & ((r_wcnt == 4'd0) | s_axi.wlast);
    assign w_ar_hs = s_axi.arvalid & w_arready;
    assign w_r_hs  = s_axi.rready & w_rvalid;

    // SLVERR when wlast disagrees with the beat count on the ending beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_widx  <= '0;
            r_wcnt  <= '0;
            r_bid   <= '0;
            r_bresp <= 2'b00;
        end else begin
            if (w_aw_hs) begin
                r_bid  <= s_axi.awid;
                r_widx <= s_axi.awaddr[ADDR_WIDTH+1:2];
                r_wcnt <= s_axi.awlen;
            end else if (w_w_hs) begin
                r_widx <= r_widx + 1'b1;
                r_wcnt <= r_wcnt - 1'b1;
            end
            if (w_w_end)
                r_bresp <= (s_axi.wlast == (r_wcnt == 4'd0)) ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.wstrb[b]) r_mem[r_widx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
        end
    end

    // Prefetch the next beat on each accepted non-final beat so bursts stream back-to-back.
    assign w_raddr = w_ar_hs ? s_axi.araddr[ADDR_WIDTH+1:2] : r_ridx + 1'b1;
    assign w_ren   = w_ar_hs | (w_r_hs & (r_rcnt != 4'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ridx  <= '0;
            r_rcnt  <= '0;
            r_rid   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rid  <= s_axi.arid;
                r_ridx <= s_axi.araddr[ADDR_WIDTH+1:2];
                r_rcnt <= s_axi.arlen;
            end else if (w_r_hs && r_rcnt != 4'd0) begin
                r_ridx <= r_ridx + 1'b1;
                r_rcnt <= r_rcnt - 1'b1;
            end
            if (w_ren) r_rdata <= r_mem[w_raddr];
        end
    end

    assign s_axi.awready = w_awready;
    assign s_axi.wready  = w_wready;
    assign s_axi.bvalid  = w_bvalid;
    assign s_axi.bid     = r_bid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = w_arready;
    assign s_axi.rvalid  = w_rvalid;
    assign s_axi.rlast   = w_rvalid & (r_rcnt == 4'd0);
    assign s_axi.rid     = r_rid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = 2'b00;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed scenarios plus concurrent random read/write
// traffic, checked every cycle against a queue-based transaction model.
`timescale 1ns/1ps
module tb_axi_sram_slave;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_sram_slave_if bus ();
    axi_sram_slave #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .s_axi(bus));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_to(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected handshake at %0t", nm, $time);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & (DEPTH - 1));
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    int          m_wq[$];
    int          m_rq[$];
    bit          m_wbusy, m_bpend, m_started;
    logic [3:0]  m_bid, m_rid;
    logic [1:0]  m_bresp;
    logic [31:0] m_rdata;
    bit          m_rknown;
    int          mb, mi;

    always @(posedge clk) begin
        if (reset) begin
            m_wq.delete();
            m_rq.delete();
            m_wbusy = 0; m_bpend = 0;
            m_bid = 0; m_rid = 0; m_bresp = 0; m_rdata = 0; m_rknown = 1;
            m_started = 1;
        end else begin
            // read side first so it sees memory as it was before this edge's write
            if (m_rq.size() == 0) begin
                if (bus.arvalid) begin
                    mb = widx(bus.araddr);
                    for (int k = 0; k <= int'(bus.arlen); k++) m_rq.push_back((mb + k) % DEPTH);
                    m_rid    = bus.arid;
                    m_rdata  = m_mem[m_rq[0]];
                    m_rknown = m_known[m_rq[0]];
                end
            end else if (bus.rready) begin
                void'(m_rq.pop_front());
                if (m_rq.size() != 0) begin
                    m_rdata  = m_mem[m_rq[0]];
                    m_rknown = m_known[m_rq[0]];
                end
            end
            if (!m_wbusy && !m_bpend) begin
                if (bus.awvalid) begin
                    mb = widx(bus.awaddr);
                    for (int k = 0; k <= int'(bus.awlen); k++) m_wq.push_back((mb + k) % DEPTH);
                    m_bid   = bus.awid;
                    m_wbusy = 1;
                end
            end else if (m_wbusy) begin
                if (bus.wvalid) begin
                    mi = m_wq.pop_front();
                    for (int b = 0; b < 4; b++)
                        if (bus.wstrb[b]) m_mem[mi][8*b +: 8] = bus.wdata[8*b +: 8];
                    m_known[mi] = m_known[mi] | (bus.wstrb == 4'hF);
                    if (bus.wlast || m_wq.size() == 0) begin
                        m_bresp = (bus.wlast && m_wq.size() == 0) ? 2'b00 : 2'b10;
                        m_wq.delete();
                        m_wbusy = 0;
                        m_bpend = 1;
                    end
                end
            end else if (bus.bready) begin
                m_bpend = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("awready", 32'(bus.awready), 32'(!m_wbusy && !m_bpend));
            chk("wready",  32'(bus.wready),  32'(m_wbusy));
            chk("bvalid",  32'(bus.bvalid),  32'(m_bpend));
            chk("bid",     32'(bus.bid),     32'(m_bid));
            chk("bresp",   32'(bus.bresp),   32'(m_bresp));
            chk("arready", 32'(bus.arready), 32'(m_rq.size() == 0));
            chk("rvalid",  32'(bus.rvalid),  32'(m_rq.size() != 0));
            chk("rlast",   32'(bus.rlast),   32'(m_rq.size() == 1));
            chk("rid",     32'(bus.rid),     32'(m_rid));
            chk("rresp",   32'(bus.rresp),   32'(0));
            if (m_rq.size() != 0 && m_rknown) chk("rdata", bus.rdata, m_rdata);
        end
    end

    // ---------------- master tasks ----------------
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [3:0]  got_bid;
    logic [1:0]  got_bresp;
    int          b_wait;
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [3:0]  rd_id [16];
    int          rd_n, rd_first;

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr_burst(input logic [31:0] addr, input int len, input logic [3:0] id,
                            input int last_at, input bit rnd);
        bit hs;
        int t;
        int nb;
        bit got;
        nb = ((last_at < len) ? last_at : len) + 1;
        bus.awaddr = addr; bus.awlen = 4'(len); bus.awid = id; bus.awvalid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk); hs = bus.awready;
            @(posedge clk); #1;
            if (hs) break;
            if (++t > 500) begin fail_to("aw_handshake"); break; end
        end
        bus.awvalid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (rnd) idle($urandom_range(0, 2));
            bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = (b == last_at); bus.wvalid = 1'b1;
            t = 0;
            forever begin
                @(negedge clk); hs = bus.wready;
                @(posedge clk); #1;
                if (hs) break;
                if (++t > 500) begin fail_to("w_handshake"); break; end
            end
            bus.wvalid = 1'b0; bus.wlast = 1'b0;
        end
        if (rnd) idle($urandom_range(0, 3));
        bus.bready = 1'b1;
        t = 0; got = 0;
        while (!got && t < 500) begin
            @(negedge clk); t++;
            if (bus.bvalid) begin got_bid = bus.bid; got_bresp = bus.bresp; got = 1; end
            @(posedge clk); #1;
        end
        bus.bready = 1'b0;
        b_wait = t;
        if (!got) fail_to("b_handshake");
    endtask

    // mode 0: rready always high, 1: low every other cycle, 2: random
    task automatic rd_burst(input logic [31:0] addr, input int len, input logic [3:0] id,
                            input int mode);
        bit hs;
        bit ph;
        int t;
        bus.araddr = addr; bus.arlen = 4'(len); bus.arid = id; bus.arvalid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk); hs = bus.arready;
            @(posedge clk); #1;
            if (hs) break;
            if (++t > 500) begin fail_to("ar_handshake"); break; end
        end
        bus.arvalid = 1'b0;
        rd_n = 0; rd_first = 0; t = 0; ph = 0;
        while (rd_n <= len && t < 500) begin
            case (mode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = ph;
                default: bus.rready = ($urandom_range(0, 2) != 0);
            endcase
            ph = !ph;
            @(negedge clk); t++;
            if (bus.rvalid && rd_first == 0) rd_first = t;
            if (bus.rvalid && bus.rready && rd_n < 16) begin
                rd_data[rd_n] = bus.rdata; rd_last[rd_n] = bus.rlast; rd_id[rd_n] = bus.rid;
                rd_n++;
            end
            @(posedge clk); #1;
        end
        bus.rready = 1'b0;
        if (rd_n <= len) fail_to("r_beats");
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        int idx;
        r   = $urandom();
        idx = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 8, DEPTH - 1) : $urandom_range(0, 47);
        return (r & 32'hFFFF_C000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit hs;
        int cnt;
        reset = 1'b1;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awvalid = 0;
        bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arvalid = 0; bus.rready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(bus.awready), 32'd1);
        chk("rst_arready", 32'(bus.arready), 32'd1);
        chk("rst_wready",  32'(bus.wready),  32'd0);
        chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_rlast",   32'(bus.rlast),   32'd0);
        chk("rst_ids",     32'({bus.bid, bus.rid}), 32'd0);
        chk("rst_resp",    32'({bus.bresp, bus.rresp}), 32'd0);
        chk("rst_rdata",   bus.rdata, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // single-beat write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        wr_burst(32'h10, 0, 4'd3, 0, 0);
        chk("t1_bid", 32'(got_bid), 32'd3);
        chk("t1_bresp", 32'(got_bresp), 32'd0);
        chk("t1_b_latency", 32'(b_wait), 32'd1);
        rd_burst(32'h10, 0, 4'd5, 0);
        chk("t1_rdata", rd_data[0], 32'hDEADBEEF);
        chk("t1_rid", 32'(rd_id[0]), 32'd5);
        chk("t1_rlast", 32'(rd_last[0]), 32'd1);
        chk("t1_r_latency", 32'(rd_first), 32'd1);

        // byte strobes
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        wr_burst(32'h20, 0, 4'd1, 0, 0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        wr_burst(32'h20, 0, 4'd1, 0, 0);
        rd_burst(32'h20, 0, 4'd2, 0);
        chk("t2_strb", rd_data[0], 32'h11BB33DD);

        // 4-beat burst read back with rready toggling
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        wr_burst(32'h100, 3, 4'd7, 3, 0);
        chk("t3_bresp", 32'(got_bresp), 32'd0);
        rd_burst(32'h100, 3, 4'd8, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_rdata", rd_data[i], 32'(i + 1));
            chk("t3_rlast", 32'(rd_last[i]), 32'(i == 3));
        end

        // wrap at top of array and address aliasing
        wd[0] = 32'hA5A50001; wd[1] = 32'hA5A50002; ws[0] = 4'hF; ws[1] = 4'hF;
        wr_burst(32'h3FFC, 1, 4'd4, 1, 0);
        chk("t4_bresp", 32'(got_bresp), 32'd0);
        rd_burst(32'h4000, 0, 4'd4, 0);
        chk("t4_alias", rd_data[0], 32'hA5A50002);
        rd_burst(32'h3FFC, 1, 4'd4, 0);
        chk("t4_wrap0", rd_data[0], 32'hA5A50001);
        chk("t4_wrap1", rd_data[1], 32'hA5A50002);

        // early wlast: len 3 but wlast on the second beat
        for (int i = 0; i < 3; i++) begin wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; end
        wr_burst(32'h200, 2, 4'd6, 2, 0);
        wd[0] = 32'hE0; wd[1] = 32'hE1;
        wr_burst(32'h200, 3, 4'd9, 1, 0);
        chk("t5_bresp", 32'(got_bresp), 32'd2);
        chk("t5_bid", 32'(got_bid), 32'd9);
        rd_burst(32'h200, 2, 4'd1, 0);
        chk("t5_w0", rd_data[0], 32'hE0);
        chk("t5_w1", rd_data[1], 32'hE1);
        chk("t5_w2", rd_data[2], 32'hC2);

        // missing wlast on a single-beat burst
        wd[0] = 32'h77; ws[0] = 4'hF;
        wr_burst(32'h300, 0, 4'd2, 1, 0);
        chk("t5b_bresp", 32'(got_bresp), 32'd2);

        // reset in the middle of a read burst
        bus.araddr = 32'h100; bus.arlen = 4'd3; bus.arid = 4'd9; bus.arvalid = 1'b1;
        cnt = 0;
        forever begin
            @(negedge clk); hs = bus.arready;
            @(posedge clk); #1;
            if (hs) break;
            if (++cnt > 500) begin fail_to("t6_ar"); break; end
        end
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        cnt = 0;
        for (int t = 0; t < 50 && cnt < 2; t++) begin
            @(negedge clk);
            if (bus.rvalid && bus.rready) cnt++;
            @(posedge clk); #1;
        end
        reset = 1'b1; bus.rready = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_rvalid", 32'(bus.rvalid), 32'd0);
        chk("t6_arready", 32'(bus.arready), 32'd1);
        @(posedge clk); #1;
        rd_burst(32'h100, 3, 4'd3, 0);
        for (int i = 0; i < 4; i++) chk("t6_rdata", rd_data[i], 32'(i + 1));
        chk("t6_rid", 32'(rd_id[3]), 32'd3);

        // concurrent random traffic
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int len;
                    int la;
                    len = $urandom_range(0, 15);
                    case ($urandom_range(0, 7))
                        0:       la = (len > 0) ? len - 1 : 0;
                        1:       la = len + 1;
                        default: la = len;
                    endcase
                    for (int i = 0; i < 16; i++) begin
                        wd[i] = $urandom();
                        ws[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
                    end
                    idle($urandom_range(0, 3));
                    wr_burst(rand_addr(), len, 4'($urandom()), la, 1);
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    idle($urandom_range(0, 3));
                    rd_burst(rand_addr(), $urandom_range(0, 15), 4'($urandom()), 2);
                end
            end
        join
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
